// File: rtl/pwm_duty_meter_pkg.sv
// Shared types and defaults for the PWM duty meter.
// Holds the FSM state enum, the counter width and a saturating increment.
package pwm_duty_meter_pkg;

  localparam int CNT_W       = 8;
  localparam int FRAME_DEF   = 64;
  localparam int TIMEOUT_DEF = 2 * FRAME_DEF;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } state_e;

  // Adds en to v, sticking at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(cnt_t v, logic en);
    if (en && (v != '1)) return v + cnt_t'(1);
    return v;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for an async input.
// Ports: i_clk, i_reset (sync, high), i_async in; o_level (s2), o_rise out.
module sync_edge
  import pwm_duty_meter_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures high time and period of a PWM input, flags a stuck input.
// Ports: i_sysclk, i_reset, i_enable, i_pulse_in, i_peak_clr in;
//        o_duty, o_period, o_duty_valid, o_stuck, o_peak out.
module pwm_duty_meter
  import pwm_duty_meter_pkg::*;
#(
  parameter int FRAME   = FRAME_DEF,
  parameter int TIMEOUT = 2 * FRAME
) (
  input  logic             i_sysclk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_pulse_in,
  input  logic             i_peak_clr,
  output logic [CNT_W-1:0] o_duty,
  output logic [CNT_W-1:0] o_period,
  output logic             o_duty_valid,
  output logic             o_stuck,
  output logic [CNT_W-1:0] o_peak
);

  localparam cnt_t TMO_LAST = cnt_t'(TIMEOUT - 1);
  localparam cnt_t FRAME_C  = cnt_t'(FRAME);

  logic   w_s2;
  logic   w_rise;

  state_e r_state;
  state_e w_state_nx;
  cnt_t   r_per;
  cnt_t   w_per_nx;
  cnt_t   r_hi;
  cnt_t   w_hi_nx;

  // Report staged one cycle ahead of the output registers.
  logic   r_pend;
  logic   w_pend_nx;
  cnt_t   r_pduty;
  cnt_t   w_pduty_nx;
  cnt_t   r_pper;
  cnt_t   w_pper_nx;
  logic   r_pstuck;
  logic   w_pstuck_nx;

  cnt_t   r_duty;
  cnt_t   r_period;
  logic   r_dv;
  logic   r_stuck;
  cnt_t   r_peak;

  logic   w_tmo;
  cnt_t   w_stuck_duty;
  cnt_t   w_clip;

  sync_edge u_sync (
    .i_clk   (i_sysclk),
    .i_reset (i_reset),
    .i_async (i_pulse_in),
    .o_level (w_s2),
    .o_rise  (w_rise)
  );

  assign w_tmo        = (r_per >= TMO_LAST);
  assign w_stuck_duty = w_s2 ? FRAME_C : '0;
  assign w_clip       = (r_hi > r_per) ? r_per : r_hi;

  always_comb begin
    w_state_nx  = r_state;
    w_per_nx    = r_per;
    w_hi_nx     = r_hi;
    w_pend_nx   = 1'b0;
    w_pduty_nx  = r_pduty;
    w_pper_nx   = r_pper;
    w_pstuck_nx = r_pstuck;

    unique case (r_state)
      IDLE: begin
        w_per_nx   = '0;
        w_hi_nx    = '0;
        w_state_nx = ARMED;
      end
      ARMED: begin
        if (w_rise) begin
          w_per_nx   = cnt_t'(1);
          w_hi_nx    = cnt_t'(1);
          w_state_nx = MEASURE;
        end else if (w_tmo) begin
          w_pend_nx   = 1'b1;
          w_pduty_nx  = w_stuck_duty;
          w_pper_nx   = '0;
          w_pstuck_nx = 1'b1;
          w_per_nx    = '0;
          w_hi_nx     = '0;
        end else begin
          w_per_nx = sat_inc(r_per, 1'b1);
        end
      end
      MEASURE: begin
        if (w_rise) begin
          w_pend_nx   = 1'b1;
          w_pduty_nx  = w_clip;
          w_pper_nx   = r_per;
          w_pstuck_nx = 1'b0;
          w_per_nx    = cnt_t'(1);
          w_hi_nx     = cnt_t'(1);
        end else if (w_tmo) begin
          w_pend_nx   = 1'b1;
          w_pduty_nx  = w_stuck_duty;
          w_pper_nx   = '0;
          w_pstuck_nx = 1'b1;
          w_per_nx    = '0;
          w_hi_nx     = '0;
          w_state_nx  = ARMED;
        end else begin
          w_per_nx = sat_inc(r_per, 1'b1);
          w_hi_nx  = sat_inc(r_hi, w_s2);
        end
      end
      default: w_state_nx = IDLE;
    endcase

    // Disable wins over everything and drops the partial period.
    if (!i_enable) begin
      w_state_nx = IDLE;
      w_per_nx   = '0;
      w_hi_nx    = '0;
      w_pend_nx  = 1'b0;
    end
  end

  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_per    <= '0;
      r_hi     <= '0;
      r_pend   <= 1'b0;
      r_pduty  <= '0;
      r_pper   <= '0;
      r_pstuck <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_per    <= w_per_nx;
      r_hi     <= w_hi_nx;
      r_pend   <= w_pend_nx;
      r_pduty  <= w_pduty_nx;
      r_pper   <= w_pper_nx;
      r_pstuck <= w_pstuck_nx;
    end
  end

  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      r_duty   <= '0;
      r_period <= '0;
      r_dv     <= 1'b0;
      r_stuck  <= 1'b0;
    end else begin
      r_dv <= r_pend;
      if (r_pend) begin
        r_duty   <= r_pduty;
        r_period <= r_pper;
        r_stuck  <= r_pstuck;
      end
    end
  end

  // A clear coinciding with a report restarts the peak from that report.
  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      r_peak <= '0;
    end else if (i_peak_clr) begin
      r_peak <= r_dv ? r_duty : '0;
    end else if (r_dv && (r_duty > r_peak)) begin
      r_peak <= r_duty;
    end
  end

  assign o_duty       = r_duty;
  assign o_period     = r_period;
  assign o_duty_valid = r_dv;
  assign o_stuck      = r_stuck;
  assign o_peak       = r_peak;

endmodule

// File: doc/pwm_duty_meter.md
PWM_DUTY_METER -- requirements
Module: pwm_duty_meter

Interface
REQ-001 Parameter FRAME, default 64: nominal PWM period in sysclk cycles (power of two, 16..128).
REQ-002 Parameter TIMEOUT, default 2*FRAME: cycles without a rising edge before the input is declared stuck.
REQ-003 sysclk  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 Enable  in  1  measurement enable; low holds the FSM in IDLE.
REQ-006 Pulse_In  in  1  asynchronous PWM input from the upstream PWM generator.
REQ-007 Peak_Clr  in  1  single-cycle request to clear the peak-hold register.
REQ-008 Duty  out  8  high-cycle count of the last completed period.
REQ-009 Period  out  8  length of the last completed period in cycles; 0 on a stuck report.
REQ-010 Duty_Valid  out  1  one-cycle strobe; Duty, Period and Stuck updated in the same cycle.
REQ-011 Stuck  out  1  set with Duty_Valid when a timeout caused the report.
REQ-012 Peak  out  8  maximum Duty reported since the last reset or Peak_Clr.

Function
REQ-013 Pulse_In SHALL pass a 2-flop synchronizer (s1, s2); s3 = s2 delayed one cycle; rise = s2 & ~s3.
REQ-014 The FSM SHALL have states IDLE, ARMED and MEASURE.
REQ-015 IDLE: counters held at 0. Go to ARMED when Enable=1.
REQ-016 ARMED (first edge not yet seen): on rise, load per_cnt=1 and hi_cnt=1, then go to MEASURE.
REQ-017 MEASURE without rise: per_cnt+1; hi_cnt+s2.
REQ-018 MEASURE with rise: register Duty=hi_cnt and Period=per_cnt, pulse Duty_Valid with Stuck=0 on the next cycle, reload per_cnt=1 and hi_cnt=1, and stay in MEASURE.
REQ-019 Timeout in MEASURE or ARMED: when per_cnt reaches TIMEOUT-1 with no rise, report Duty=FRAME if s2=1 else 0, Period=0, Stuck=1, and Duty_Valid=1 for one cycle; clear the counters and go to ARMED.
REQ-020 In ARMED, per_cnt SHALL count from entry, so the timeout also covers the case where no first edge ever arrives.
REQ-021 Counters SHALL saturate at 255 and never wrap.
REQ-022 Duty SHALL be clipped to Period when hi_cnt > Period (defensive only; unreachable in normal operation).
REQ-023 Enable deasserted in any state: go to IDLE on the next cycle; no report; Duty, Period and Peak hold their values.
REQ-024 Latency: Duty_Valid SHALL assert exactly 4 cycles after the Pulse_In rising edge that closes a period (2 synchronizer + 1 edge + 1 output register).
REQ-025 Peak update: on Duty_Valid, if the new Duty > Peak, then Peak <= Duty on the following cycle.
REQ-026 Peak_Clr and Duty_Valid in the same cycle: clear first, then load Peak with the new Duty.
REQ-027 Duty_Valid SHALL never assert on two consecutive cycles; the minimum period is 2.

Reset
REQ-028 On reset=1 at a clock edge, all of the following SHALL be 0: Duty, Period, Duty_Valid, Stuck, Peak, counters, and synchronizer flops; the FSM goes to IDLE.
REQ-029 Reset asserted mid-period SHALL discard the partial measurement; the first report after release SHALL need two fresh rising edges.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE, ARMED, MEASURE), the counter width constant (8), and the FRAME and TIMEOUT defaults.
REQ-031 The synchronizer plus edge detector SHALL be a separate sub-module, sync_edge (outputs level s2 and rise), reusable for the switch inputs.

Verification
REQ-032 Enable=1; Pulse_In = 16 high / 48 low, repeating every 64 cycles -> first Duty_Valid after the second edge; then Duty=16, Period=64, Stuck=0 every 64 cycles.
REQ-033 Pulse_In held at 0 after one edge -> Duty_Valid with Duty=0, Period=0, Stuck=1 at TIMEOUT=128 cycles; repeats every 128 cycles.
REQ-034 Pulse_In held at 1 -> stuck reports with Duty=64, Period=0, Stuck=1.
REQ-035 Duty sweep 0..63 over successive periods (amplitude ramp), then Peak_Clr in the same cycle as a Duty=10 report -> Peak tracks 63, then reads 10.
REQ-036 Reset asserted at cycle 30 of a period, released at 35 -> all outputs 0; no Duty_Valid until two rising edges after release.
REQ-037 Enable dropped mid-period for 10 cycles -> no report; outputs hold; measurement resumes after two edges.
